// File: rtl/exp_dma_req_pkg.sv
// Shared bus-arbitration definitions: DMA requester state encoding,
// tenure / hold-off defaults and the shared counter width.
package exp_dma_req_pkg;

    localparam int DEF_MAX_TENURE = 16;
    localparam int DEF_HOLDOFF    = 4;
    localparam int CNT_W          = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_WAIT_IDLE = 3'd2,
        ST_OWN       = 3'd3,
        ST_RELEASE   = 3'd4,
        ST_HOLD      = 3'd5
    } state_t;

endpackage

// File: rtl/exp_dma_req_if.sv
// Signal bundle between the expansion DMA requester, the 030 bus arbiter
// and the expansion DMA engine.
interface exp_dma_req_if;

    // Handshake: dma_req is a level sampled only in IDLE together with
    // dma_len; exp_br/exp_bg form a request/grant pair, and the engine runs
    // bus cycles only while dma_go is high, reporting each with cycle_done.
    logic       acc_disable;
    logic       as30_n;
    logic       exp_bg;
    logic       dma_req;
    logic [7:0] dma_len;
    logic       cycle_done;
    logic       exp_br;
    logic       dma_go;
    logic       dma_done;
    logic       dma_abort;
    logic [7:0] remain;

    modport master (
        input  acc_disable, as30_n, exp_bg, dma_req, dma_len, cycle_done,
        output exp_br, dma_go, dma_done, dma_abort, remain
    );

    modport slave (
        output acc_disable, as30_n, exp_bg, dma_req, dma_len, cycle_done,
        input  exp_br, dma_go, dma_done, dma_abort, remain
    );

endinterface

// File: rtl/exp_dma_req_arb_cnt.sv
// Clearable up-counter shared by the bus tenure and hold-off timing; the
// two uses never overlap because OWN and HOLD are distinct states.
module arb_cnt
    import exp_dma_req_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/exp_dma_req.sv
// Expansion DMA bus requester: asks the 030 arbiter for the bus, runs the
// DMA engine in bounded tenures and backs off between tenures.
module exp_dma_req
    import exp_dma_req_pkg::*;
#(
    parameter int MAX_TENURE = DEF_MAX_TENURE,
    parameter int HOLDOFF    = DEF_HOLDOFF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    exp_dma_req_if.master     bus,
    output state_t            o_state
);

    localparam logic [CNT_W-1:0] TENURE_LAST = CNT_W'(MAX_TENURE - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLDOFF - 1);

    state_t     r_state;
    logic       r_exp_br;
    logic       r_dma_go;
    logic       r_dma_done;
    logic       r_dma_abort;
    logic [7:0] r_remain;

    logic             w_bg;
    logic             w_hit;
    logic             w_last;
    logic             w_tenure_end;
    logic             w_enter_own;
    logic             w_enter_hold;
    logic             w_hold_end;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic [CNT_W-1:0] w_cnt;
    logic [7:0]       w_remain_nxt;

    // The strap masks the grant so a stale grant can never start a tenure.
    assign w_bg         = bus.exp_bg & ~bus.acc_disable;
    assign w_hit        = (r_state == ST_OWN) && bus.cycle_done && (r_remain != 8'd0);
    assign w_remain_nxt = r_remain - {7'd0, w_hit};
    assign w_last       = w_hit && (r_remain == 8'd1);
    assign w_tenure_end = w_hit && (w_cnt == TENURE_LAST);
    assign w_enter_own  = ((r_state == ST_REQ) || (r_state == ST_WAIT_IDLE)) && w_bg && bus.as30_n;
    assign w_enter_hold = (r_state == ST_RELEASE) && !w_bg;
    assign w_hold_end   = (r_state == ST_HOLD) && (w_cnt == HOLD_LAST);
    assign w_cnt_clr    = bus.acc_disable || w_enter_own || w_enter_hold;
    assign w_cnt_inc    = w_hit || ((r_state == ST_HOLD) && !w_hold_end);

    arb_cnt u_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_cnt_inc),
        .o_count (w_cnt)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_exp_br    <= 1'b0;
            r_dma_go    <= 1'b0;
            r_dma_done  <= 1'b0;
            r_dma_abort <= 1'b0;
            r_remain    <= 8'd0;
        end else begin
            r_dma_done  <= 1'b0;
            r_dma_abort <= 1'b0;
            if (bus.acc_disable) begin
                r_state     <= ST_IDLE;
                r_exp_br    <= 1'b0;
                r_dma_go    <= 1'b0;
                r_remain    <= 8'd0;
                r_dma_abort <= (r_remain != 8'd0);
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.dma_req && (bus.dma_len != 8'd0)) begin
                            r_remain <= bus.dma_len;
                            r_state  <= ST_REQ;
                            r_exp_br <= 1'b1;
                        end
                    end
                    ST_REQ: begin
                        if (w_enter_own) begin
                            r_state  <= ST_OWN;
                            r_dma_go <= 1'b1;
                        end else if (w_bg) begin
                            r_state <= ST_WAIT_IDLE;
                        end
                    end
                    ST_WAIT_IDLE: begin
                        if (!w_bg) begin
                            r_state <= ST_REQ;
                        end else if (bus.as30_n) begin
                            r_state  <= ST_OWN;
                            r_dma_go <= 1'b1;
                        end
                    end
                    ST_OWN: begin
                        // A final cycle completing as the grant drops counts as done.
                        r_remain <= w_remain_nxt;
                        if (w_last) begin
                            r_state    <= ST_RELEASE;
                            r_dma_go   <= 1'b0;
                            r_exp_br   <= 1'b0;
                            r_dma_done <= 1'b1;
                        end else if (!w_bg) begin
                            r_state     <= ST_RELEASE;
                            r_dma_go    <= 1'b0;
                            r_exp_br    <= 1'b0;
                            r_dma_abort <= 1'b1;
                        end else if (w_tenure_end) begin
                            r_state  <= ST_RELEASE;
                            r_dma_go <= 1'b0;
                            r_exp_br <= 1'b0;
                        end
                    end
                    ST_RELEASE: begin
                        r_exp_br <= 1'b0;
                        if (!w_bg) begin
                            r_state <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (w_hold_end) begin
                            if (r_remain != 8'd0) begin
                                r_state  <= ST_REQ;
                                r_exp_br <= 1'b1;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_exp_br <= 1'b0;
                        r_dma_go <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.exp_br    = r_exp_br;
    assign bus.dma_go    = r_dma_go;
    assign bus.dma_done  = r_dma_done;
    assign bus.dma_abort = r_dma_abort;
    assign bus.remain    = r_remain;
    assign o_state       = r_state;

endmodule

// File: tb/tb_exp_dma_req.sv
// Bench for exp_dma_req: scenario tasks with inline checks plus a pulse
// scoreboard for DMA_DONE / DMA_ABORT events.
module tb_exp_dma_req;
    import exp_dma_req_pkg::*;

    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    state_t state;

    always #5 clk = ~clk;

    exp_dma_req_if bus();

    exp_dma_req #(.MAX_TENURE(16), .HOLDOFF(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus),
        .o_state (state)
    );

    localparam logic [1:0] K_DONE  = 2'b10;
    localparam logic [1:0] K_ABORT = 2'b01;

    logic [9:0] exp_q[$];
    logic [9:0] mon_got;
    logic [9:0] mon_want;
    int n_cmp = 0;
    int n_err = 0;

    // Pulse scoreboard: {done, abort, remain} seen against the queued expectation.
    always @(negedge clk) begin
        if (rst_n && (bus.dma_done || bus.dma_abort)) begin
            mon_got = {bus.dma_done, bus.dma_abort, bus.remain};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pulse_unexpected: got done/abort=%b remain=%0d, required no pulse",
                         mon_got[9:8], mon_got[7:0]);
            end else begin
                mon_want = exp_q.pop_front();
                if (mon_got !== mon_want) begin
                    n_err++;
                    $display("FAIL pulse_check: got done/abort=%b remain=%0d, required done/abort=%b remain=%0d",
                             mon_got[9:8], mon_got[7:0], mon_want[9:8], mon_want[7:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task tick();
        @(posedge clk);
        #1;
    endtask

    task drive_idle();
        bus.acc_disable = 1'b0;
        bus.as30_n      = 1'b1;
        bus.exp_bg      = 1'b0;
        bus.dma_req     = 1'b0;
        bus.dma_len     = 8'd0;
        bus.cycle_done  = 1'b0;
    endtask

    task start_req(input logic [7:0] len);
        bus.dma_req = 1'b1;
        bus.dma_len = len;
        tick();
        bus.dma_req = 1'b0;
        bus.dma_len = 8'd0;
    endtask

    task wait_state(input state_t s, input int budget, input string name);
        int k;
        k = 0;
        while (state !== s && k < budget) begin
            tick();
            k++;
        end
        n_cmp++;
        if (state !== s) begin
            n_err++;
            $display("FAIL %s: state %s after %0d cycles, required %s", name, state.name(), k, s.name());
        end
    endtask

    task test_reset();
        drive_idle();
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({bus.exp_br, bus.dma_go, bus.dma_done, bus.dma_abort} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_outputs: got br/go/done/abort=%b, required 0000",
                     {bus.exp_br, bus.dma_go, bus.dma_done, bus.dma_abort});
        end
        n_cmp++;
        if (bus.remain !== 8'd0) begin
            n_err++;
            $display("FAIL reset_remain: got %0d, required 0", bus.remain);
        end
        n_cmp++;
        if (state !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset_state: got %s, required ST_IDLE", state.name());
        end
        rst_n = 1'b1;
        tick();
    endtask

    task test_basic();
        int hold;
        start_req(8'd3);
        n_cmp++;
        if (bus.exp_br !== 1'b1 || bus.remain !== 8'd3 || state !== ST_REQ) begin
            n_err++;
            $display("FAIL basic_req: got br=%b remain=%0d state=%s, required br=1 remain=3 ST_REQ",
                     bus.exp_br, bus.remain, state.name());
        end
        tick();
        tick();
        bus.exp_bg = 1'b1;
        tick();
        n_cmp++;
        if (bus.dma_go !== 1'b1 || state !== ST_OWN) begin
            n_err++;
            $display("FAIL basic_own: got go=%b state=%s, required go=1 ST_OWN", bus.dma_go, state.name());
        end
        exp_q.push_back({K_DONE, 8'd0});
        for (int i = 0; i < 3; i++) begin
            bus.cycle_done = 1'b1;
            tick();
            if (i < 2) begin
                n_cmp++;
                if (bus.dma_go !== 1'b1 || bus.remain !== 8'(2 - i)) begin
                    n_err++;
                    $display("FAIL basic_cycle%0d: got go=%b remain=%0d, required go=1 remain=%0d",
                             i, bus.dma_go, bus.remain, 2 - i);
                end
            end
        end
        bus.cycle_done = 1'b0;
        n_cmp++;
        if (bus.dma_go !== 1'b0 || bus.exp_br !== 1'b0 || bus.remain !== 8'd0 || state !== ST_RELEASE) begin
            n_err++;
            $display("FAIL basic_release: got go=%b br=%b remain=%0d state=%s, required 0 0 0 ST_RELEASE",
                     bus.dma_go, bus.exp_br, bus.remain, state.name());
        end
        bus.exp_bg = 1'b0;
        tick();
        hold = 0;
        while (state == ST_HOLD && hold < 20) begin
            hold++;
            tick();
        end
        n_cmp++;
        if (hold != 4 || state !== ST_IDLE) begin
            n_err++;
            $display("FAIL basic_hold: got %0d hold cycles then %s, required 4 then ST_IDLE", hold, state.name());
        end
    endtask

    task test_wait_idle();
        start_req(8'd1);
        bus.as30_n = 1'b0;
        bus.exp_bg = 1'b1;
        tick();
        n_cmp++;
        if (state !== ST_WAIT_IDLE) begin
            n_err++;
            $display("FAIL wait_idle_enter: got %s, required ST_WAIT_IDLE", state.name());
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (bus.dma_go !== 1'b0) begin
                n_err++;
                $display("FAIL wait_idle_go%0d: got go=%b, required 0", i, bus.dma_go);
            end
            tick();
        end
        bus.as30_n = 1'b1;
        n_cmp++;
        if (bus.dma_go !== 1'b0) begin
            n_err++;
            $display("FAIL wait_idle_as_rise: got go=%b, required 0", bus.dma_go);
        end
        tick();
        n_cmp++;
        if (bus.dma_go !== 1'b1 || state !== ST_OWN) begin
            n_err++;
            $display("FAIL wait_idle_own: got go=%b state=%s, required go=1 ST_OWN", bus.dma_go, state.name());
        end
        exp_q.push_back({K_DONE, 8'd0});
        bus.cycle_done = 1'b1;
        tick();
        bus.cycle_done = 1'b0;
        bus.exp_bg = 1'b0;
        wait_state(ST_IDLE, 20, "wait_idle_return");
    endtask

    task test_grant_loss();
        start_req(8'd12);
        bus.exp_bg = 1'b1;
        tick();
        bus.cycle_done = 1'b1;
        tick();
        tick();
        bus.cycle_done = 1'b0;
        n_cmp++;
        if (bus.remain !== 8'd10) begin
            n_err++;
            $display("FAIL loss_pre_remain: got %0d, required 10", bus.remain);
        end
        exp_q.push_back({K_ABORT, 8'd9});
        bus.exp_bg = 1'b0;
        bus.cycle_done = 1'b1;
        tick();
        bus.cycle_done = 1'b0;
        n_cmp++;
        if (bus.dma_go !== 1'b0 || bus.remain !== 8'd9 || state !== ST_RELEASE) begin
            n_err++;
            $display("FAIL loss_release: got go=%b remain=%0d state=%s, required go=0 remain=9 ST_RELEASE",
                     bus.dma_go, bus.remain, state.name());
        end
        tick();
        n_cmp++;
        if (bus.dma_abort !== 1'b0) begin
            n_err++;
            $display("FAIL loss_abort_width: got abort=%b, required 0", bus.dma_abort);
        end
        wait_state(ST_REQ, 20, "loss_rerequest");
        n_cmp++;
        if (bus.exp_br !== 1'b1 || bus.remain !== 8'd9) begin
            n_err++;
            $display("FAIL loss_rerequest_out: got br=%b remain=%0d, required br=1 remain=9", bus.exp_br, bus.remain);
        end
        exp_q.push_back({K_ABORT, 8'd0});
        bus.acc_disable = 1'b1;
        tick();
        bus.acc_disable = 1'b0;
        n_cmp++;
        if (bus.remain !== 8'd0 || state !== ST_IDLE) begin
            n_err++;
            $display("FAIL loss_cleanup: got remain=%0d state=%s, required 0 ST_IDLE", bus.remain, state.name());
        end
    endtask

    task test_disable();
        start_req(8'd8);
        bus.exp_bg = 1'b1;
        tick();
        bus.cycle_done = 1'b1;
        repeat (3) tick();
        bus.cycle_done = 1'b0;
        n_cmp++;
        if (bus.remain !== 8'd5) begin
            n_err++;
            $display("FAIL disable_pre_remain: got %0d, required 5", bus.remain);
        end
        exp_q.push_back({K_ABORT, 8'd0});
        bus.acc_disable = 1'b1;
        bus.dma_req = 1'b1;
        bus.dma_len = 8'd4;
        tick();
        n_cmp++;
        if (bus.exp_br !== 1'b0 || bus.dma_go !== 1'b0 || bus.remain !== 8'd0 || state !== ST_IDLE) begin
            n_err++;
            $display("FAIL disable_force: got br=%b go=%b remain=%0d state=%s, required 0 0 0 ST_IDLE",
                     bus.exp_br, bus.dma_go, bus.remain, state.name());
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (bus.exp_br !== 1'b0 || state !== ST_IDLE) begin
                n_err++;
                $display("FAIL disable_ignore%0d: got br=%b state=%s, required br=0 ST_IDLE",
                         i, bus.exp_br, state.name());
            end
        end
        drive_idle();
        tick();
    endtask

    task test_tenure();
        int lens[3];
        logic [7:0] rem_after[3];
        int n;
        int low;
        lens = '{16, 16, 8};
        rem_after = '{8'd24, 8'd8, 8'd0};
        exp_q.push_back({K_DONE, 8'd0});
        start_req(8'd40);
        for (int t = 0; t < 3; t++) begin
            wait_state(ST_REQ, 30, "tenure_req");
            bus.exp_bg = 1'b1;
            tick();
            n = 0;
            bus.cycle_done = 1'b1;
            do begin
                tick();
                n++;
            end while (bus.dma_go && n < 50);
            bus.cycle_done = 1'b0;
            n_cmp++;
            if (n != lens[t] || bus.remain !== rem_after[t]) begin
                n_err++;
                $display("FAIL tenure%0d: got %0d cycles remain=%0d, required %0d cycles remain=%0d",
                         t, n, bus.remain, lens[t], rem_after[t]);
            end
            bus.exp_bg = 1'b0;
            if (t < 2) begin
                low = 1;
                while (bus.exp_br == 1'b0 && low < 40) begin
                    tick();
                    if (bus.exp_br == 1'b0) low++;
                end
                n_cmp++;
                if (bus.exp_br !== 1'b1 || low < 4) begin
                    n_err++;
                    $display("FAIL tenure_gap%0d: got br=%b after %0d low cycles, required br=1 after at least 4",
                             t, bus.exp_br, low);
                end
            end
        end
        wait_state(ST_IDLE, 20, "tenure_idle");
    endtask

    task test_random();
        int len;
        int k;
        int n;
        for (int r = 0; r < 4; r++) begin
            len = $urandom_range(1, 15);
            exp_q.push_back({K_DONE, 8'd0});
            start_req(8'(len));
            bus.exp_bg = 1'b1;
            tick();
            k = 0;
            n = 0;
            while (state == ST_OWN && n < 100) begin
                bus.cycle_done = ($urandom_range(0, 2) != 0);
                if (bus.cycle_done) k++;
                tick();
                n++;
            end
            bus.cycle_done = 1'b0;
            n_cmp++;
            if (k != len || bus.remain !== 8'd0 || state !== ST_RELEASE) begin
                n_err++;
                $display("FAIL random%0d: got %0d pulses remain=%0d state=%s, required %0d pulses remain=0 ST_RELEASE",
                         r, k, bus.remain, state.name(), len);
            end
            bus.exp_bg = 1'b0;
            wait_state(ST_IDLE, 20, "random_idle");
        end
    endtask

    task test_reset_mid();
        start_req(8'd6);
        bus.exp_bg = 1'b1;
        tick();
        bus.cycle_done = 1'b1;
        tick();
        bus.cycle_done = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.exp_br, bus.dma_go, bus.dma_done, bus.dma_abort} !== 4'b0000 ||
            bus.remain !== 8'd0 || state !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset_async: got br/go/done/abort=%b remain=%0d state=%s, required 0000 0 ST_IDLE",
                     {bus.exp_br, bus.dma_go, bus.dma_done, bus.dma_abort}, bus.remain, state.name());
        end
        bus.exp_bg = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.dma_req = 1'b1;
        bus.dma_len = 8'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (bus.exp_br !== 1'b0 || state !== ST_IDLE) begin
                n_err++;
                $display("FAIL len_zero%0d: got br=%b state=%s, required br=0 ST_IDLE", i, bus.exp_br, state.name());
            end
        end
        drive_idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_idle();
        test_grant_loss();
        test_disable();
        test_tenure();
        test_random();
        test_reset_mid();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pulse_leftover: got %0d expected pulses never seen, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exp_dma_req.md
EXP_DMA_REQ -- requirements
Module: exp_dma_req

Interface
REQ-001 Parameter MAX_TENURE, default 16: maximum bus cycles per tenure before a forced release.
REQ-002 Parameter HOLDOFF, default 4: idle CLK cycles after a release before the block may re-request.
REQ-003 CLK  in  1  system clock; all state SHALL be clocked on the rising edge.
REQ-004 RESET  in  1  asynchronous, active-low reset.
REQ-005 DISABLE  in  1  accelerator-disable strap; high forces the block inactive.
REQ-006 AS30  in  1  030 address strobe, active-low; high means no cycle is in flight.
REQ-007 EXP_BG  in  1  grant from the arbiter, high means granted; treated as 0 while DISABLE=1.
REQ-008 DMA_REQ  in  1  level request from the expansion DMA engine.
REQ-009 DMA_LEN  in  8  bus cycles requested; sampled on request acceptance.
REQ-010 CYCLE_DONE  in  1  single-cycle pulse, one per completed DMA bus cycle.
REQ-011 EXP_BR  out  1  bus request to the arbiter, high means requesting.
REQ-012 DMA_GO  out  1  engine may run bus cycles while high.
REQ-013 DMA_DONE  out  1  one-cycle pulse when all DMA_LEN cycles have completed.
REQ-014 DMA_ABORT  out  1  one-cycle pulse when a transfer is killed by DISABLE or grant loss.
REQ-015 REMAIN  out  8  cycles still outstanding.

Function
REQ-016 States SHALL be IDLE, REQ, WAIT_IDLE, OWN, RELEASE and HOLD, with all outputs registered.
REQ-017 IDLE: on DMA_REQ=1, DMA_LEN!=0 and DISABLE=0, the block SHALL load REMAIN=DMA_LEN, go to REQ and drive EXP_BR=1 on the next edge.
REQ-018 IDLE: DMA_REQ with DMA_LEN=0 SHALL be ignored (no EXP_BR, no pulse).
REQ-019 REQ: on EXP_BG=1 and AS30=1 the block SHALL go to OWN with DMA_GO=1 one cycle later; on EXP_BG=1 and AS30=0 it SHALL go to WAIT_IDLE.
REQ-020 WAIT_IDLE: the block SHALL stay until AS30=1, then go to OWN; if EXP_BG drops first, it SHALL return to REQ.
REQ-021 OWN: each CYCLE_DONE SHALL decrement REMAIN by 1 and increment an internal tenure counter, which is cleared on entry to OWN.
REQ-022 CYCLE_DONE while REMAIN=0, or outside OWN, SHALL be ignored; REMAIN SHALL never wrap.
REQ-023 OWN: when REMAIN goes 1->0, the block SHALL go to RELEASE, drive DMA_GO=0 and EXP_BR=0, and pulse DMA_DONE in the same cycle.
REQ-024 OWN: when the tenure counter reaches MAX_TENURE with REMAIN>0, the block SHALL go to RELEASE with no DMA_DONE and keep REMAIN.
REQ-025 OWN: if EXP_BG falls, the block SHALL drop DMA_GO, pulse DMA_ABORT, keep REMAIN and go to RELEASE; a CYCLE_DONE in that same cycle SHALL still be counted.
REQ-026 RELEASE: the block SHALL hold EXP_BR=0 until EXP_BG=0, then go to HOLD.
REQ-027 HOLD: the block SHALL count HOLDOFF cycles, then go to REQ if REMAIN>0, otherwise to IDLE.
REQ-028 DISABLE=1 in any state SHALL, on the next edge, force IDLE, EXP_BR=0, DMA_GO=0 and REMAIN=0, and SHALL pulse DMA_ABORT if REMAIN was nonzero.
REQ-029 DMA_DONE and DMA_ABORT SHALL never assert in the same cycle; DISABLE takes priority.

Reset
REQ-030 RESET low SHALL asynchronously force IDLE, EXP_BR=0, DMA_GO=0, DMA_DONE=0, DMA_ABORT=0, REMAIN=0 and clear both internal counters.
REQ-031 Reset deassertion mid-operation SHALL resume from IDLE; no request SHALL be remembered across reset.

Structure
REQ-032 State encoding and the MAX_TENURE and HOLDOFF defaults SHALL live in the shared bus-arbitration package.
REQ-033 The block SHALL be a single module; the tenure and hold-off counters MAY share one sub-module, arb_cnt.

Verification
REQ-034 DMA_LEN=3, grant 2 cycles after EXP_BR, AS30=1, three CYCLE_DONE pulses -> DMA_GO high for the three cycles, DMA_DONE pulses once, REMAIN=0, IDLE after 4 HOLD cycles.
REQ-035 DMA_LEN=40, MAX_TENURE=16 -> three tenures of 16, 16 and 8 cycles, each separated by EXP_BR low for at least 4 cycles, with a single DMA_DONE at the end.
REQ-036 Grant arrives while AS30=0 for 5 cycles -> DMA_GO stays 0 until the cycle after AS30 rises.
REQ-037 EXP_BG drops in OWN with REMAIN=10 together with CYCLE_DONE -> DMA_ABORT pulses, REMAIN=9, and the block re-requests after HOLD.
REQ-038 DISABLE asserted in OWN with REMAIN=5 -> next edge gives EXP_BR=0, DMA_GO=0, REMAIN=0, one DMA_ABORT; DMA_REQ is ignored while DISABLE=1.
REQ-039 RESET pulsed low mid-OWN -> all outputs 0 immediately; after release, DMA_LEN=0 with DMA_REQ=1 produces no EXP_BR.
